// File: rtl/up_fetch_if.sv
// Bus bundle between up_fetch, up_memory, the decoder and the execute stage.
// The fetch unit takes the master modport; the surrounding system takes the slave modport.
interface up_fetch_if;
   logic [7:0] mem_address;
   logic [7:0] mem_in;
   logic       mem_we;
   logic [7:0] mem_out;
   logic       mem_re;
   logic       jump;
   logic [7:0] jump_pc;
   // ins_*: the decoder takes the head byte on any rising edge where ins_valid and ins_ready
   // are both high. ins_valid never depends on ins_ready. ls_req is held high until ls_ack.
   logic       ins_valid;
   logic       ins_ready;
   logic [7:0] ins_data;
   logic [7:0] ins_pc;
   logic       ls_req;
   logic       ls_we;
   logic [7:0] ls_addr;
   logic [7:0] ls_wdata;
   logic [7:0] ls_rdata;
   logic       ls_ack;
   logic       dbg_state;

   modport master (
      output mem_address, mem_in, mem_we, ins_valid, ins_data, ins_pc,
             ls_rdata, ls_ack, dbg_state,
      input  mem_out, mem_re, jump, jump_pc, ins_ready, ls_req, ls_we,
             ls_addr, ls_wdata
   );

   modport slave (
      input  mem_address, mem_in, mem_we, ins_valid, ins_data, ins_pc,
             ls_rdata, ls_ack, dbg_state,
      output mem_out, mem_re, jump, jump_pc, ins_ready, ls_req, ls_we,
             ls_addr, ls_wdata
   );
endinterface

// File: rtl/up_fetch.sv
// Instruction prefetcher and arbiter for the single up_memory port. A load or store
// from execute wins the port; otherwise sequential bytes are fetched into a small FIFO.
module up_fetch #(
   parameter int         DEPTH    = 4,
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input logic         clk,
   input logic         rst,
   up_fetch_if.master  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic {S_FREE = 1'b0, S_ACK = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [7:0]    pc_q, pc_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [7:0]    fifo_data_q [DEPTH];
   logic [7:0]    fifo_data_d [DEPTH];
   logic [7:0]    fifo_pc_q [DEPTH];
   logic [7:0]    fifo_pc_d [DEPTH];
   logic [7:0]    ls_rdata_q, ls_rdata_d;
   logic          ls_cycle, push, pop;

   // The cycle after an access is always handed back to fetch, even if ls_req is still high.
   assign ls_cycle = (state_q == S_FREE) && bus.ls_req;
   assign push     = !ls_cycle && (cnt_q != FULL) && bus.mem_re && !bus.jump;
   assign pop      = (cnt_q != '0) && bus.ins_ready && !bus.jump;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_FREE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FREE:  if (bus.ls_req) state_d = S_ACK;
         S_ACK:   state_d = S_FREE;
         default: state_d = S_FREE;
      endcase
   end

   always_comb begin
      bus.mem_address = ls_cycle ? bus.ls_addr : pc_q;
      bus.mem_we      = ls_cycle && bus.ls_we && !rst;
      bus.mem_in      = ls_cycle ? bus.ls_wdata : 8'h00;
      bus.ls_ack      = (state_q == S_ACK);
      bus.dbg_state   = state_q;
   end

   always_comb begin
      pc_d        = pc_q;
      cnt_d       = cnt_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      fifo_data_d = fifo_data_q;
      fifo_pc_d   = fifo_pc_q;
      ls_rdata_d  = ls_rdata_q;
      if (bus.jump) begin
         cnt_d    = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         pc_d     = bus.jump_pc;
      end else begin
         if (push) begin
            fifo_data_d[wr_ptr_q] = bus.mem_out;
            fifo_pc_d[wr_ptr_q]   = pc_q;
            wr_ptr_d              = wr_ptr_q + AW'(1);
            pc_d                  = pc_q + 8'd1;
         end
         if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
         if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
         else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
      end
      if (ls_cycle && !bus.ls_we) ls_rdata_d = bus.mem_out;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         cnt_q      <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         ls_rdata_q <= 8'h00;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_data_q[i] <= 8'h00;
            fifo_pc_q[i]   <= 8'h00;
         end
      end else begin
         pc_q        <= pc_d;
         cnt_q       <= cnt_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         ls_rdata_q  <= ls_rdata_d;
         fifo_data_q <= fifo_data_d;
         fifo_pc_q   <= fifo_pc_d;
      end
   end

   // Empty FIFO presents zeros rather than whatever stale entry the read pointer sits on.
   assign bus.ins_valid = (cnt_q != '0);
   assign bus.ins_data  = (cnt_q != '0) ? fifo_data_q[rd_ptr_q] : 8'h00;
   assign bus.ins_pc    = (cnt_q != '0) ? fifo_pc_q[rd_ptr_q] : 8'h00;
   assign bus.ls_rdata  = ls_rdata_q;
endmodule

// File: tb/tb_up_fetch.sv
// Directed bench for up_fetch: a behavioural up_memory, per-cycle checks of the
// fetch stream, jump flush, load/store arbitration and asynchronous reset.
module tb_up_fetch;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   up_fetch_if bus ();
   up_fetch #(.DEPTH(4), .RESET_PC(8'h00)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [7:0] mem [256];
   assign bus.mem_out = mem[bus.mem_address];
   always @(posedge clk) if (bus.mem_we) mem[bus.mem_address] <= bus.mem_in;

   int n_cmp = 0;
   int n_mis = 0;
   logic [7:0] exp_q [$];

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      bus.ls_req  = 1'b0;
      bus.jump    = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   // Scoreboard: every byte the decoder takes must be the next expected PC.
   task automatic accept();
      if (bus.ins_valid && bus.ins_ready) begin
         if (exp_q.size() == 0) check("sb_underflow", {8'h00, bus.ins_pc}, 16'hxxxx);
         else                   check("seq_pc", {8'h00, bus.ins_pc}, {8'h00, exp_q.pop_front()});
      end
   endtask

   task automatic stream(input int n);
      repeat (n) begin
         accept();
         tick();
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h02] = 8'h6C;
      mem[8'h04] = 8'h99;
      mem[8'h08] = 8'hBB;
      mem[8'h09] = 8'h3C;
      mem[8'hFF] = 8'hE7;
      bus.mem_re    = 1'b1;
      bus.jump      = 1'b0;
      bus.jump_pc   = 8'h00;
      bus.ins_ready = 1'b1;
      bus.ls_req    = 1'b0;
      bus.ls_we     = 1'b0;
      bus.ls_addr   = 8'h00;
      bus.ls_wdata  = 8'h00;

      // reset state and streaming from RESET_PC
      #1;
      check("rst_valid", {15'd0, bus.ins_valid}, 16'h0000);
      check("rst_ack", {15'd0, bus.ls_ack}, 16'h0000);
      check("rst_rdata", {8'h00, bus.ls_rdata}, 16'h0000);
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("t1_addr0", {8'h00, bus.mem_address}, 16'h0000);
      check("t1_we0", {15'd0, bus.mem_we}, 16'h0000);
      tick(); check("t1_head0", {bus.ins_pc, bus.ins_data}, 16'h0000);
      tick(); check("t1_head1", {bus.ins_pc, bus.ins_data}, 16'h0100);
      tick(); check("t1_head2", {bus.ins_pc, bus.ins_data}, 16'h026C);
      tick(); check("t1_head3", {bus.ins_pc, bus.ins_data}, 16'h0300);
      tick(); check("t1_head4", {bus.ins_pc, bus.ins_data}, 16'h0499);

      // fill to DEPTH with the decoder stalled, then drain
      bus.ins_ready = 1'b0;
      do_reset();
      repeat (6) tick();
      check("t2_full_addr", {8'h00, bus.mem_address}, 16'h0004);
      check("t2_full_head", {bus.ins_pc, bus.ins_data}, 16'h0000);
      bus.ins_ready = 1'b1;
      #1;
      check("t2_drain0", {bus.ins_pc, bus.ins_data}, 16'h0000);
      tick(); check("t2_drain1", {bus.ins_pc, bus.ins_data}, 16'h0100);
      tick(); check("t2_drain2", {bus.ins_pc, bus.ins_data}, 16'h026C);
      tick(); check("t2_drain3", {bus.ins_pc, bus.ins_data}, 16'h0300);
      tick(); check("t2_resume", {bus.ins_pc, bus.ins_data}, 16'h0499);

      // jump with three stale entries queued
      bus.ins_ready = 1'b0;
      do_reset();
      repeat (3) tick();
      check("t3_pre_head", {bus.ins_pc, 7'd0, bus.ins_valid}, 16'h0001);
      bus.jump    = 1'b1;
      bus.jump_pc = 8'h08;
      #1;
      tick();
      bus.jump = 1'b0;
      #1;
      check("t3_flushed", {15'd0, bus.ins_valid}, 16'h0000);
      tick();
      check("t3_target", {bus.ins_pc, bus.ins_data}, 16'h08BB);
      check("t3_valid", {15'd0, bus.ins_valid}, 16'h0001);

      // store then load while streaming
      bus.ins_ready = 1'b1;
      for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h08 + i));
      #1;
      stream(4);
      bus.ls_req   = 1'b1;
      bus.ls_we    = 1'b1;
      bus.ls_addr  = 8'h20;
      bus.ls_wdata = 8'h5A;
      #1;
      check("t4_st_we", {15'd0, bus.mem_we}, 16'h0001);
      check("t4_st_bus", {bus.mem_address, bus.mem_in}, 16'h205A);
      accept();
      tick();
      bus.ls_req = 1'b0;
      #1;
      check("t4_st_ack", {15'd0, bus.ls_ack}, 16'h0001);
      check("t4_st_we1", {15'd0, bus.mem_we}, 16'h0000);
      check("t4_st_rdata", {8'h00, bus.ls_rdata}, 16'h0000);
      accept();
      tick();
      check("t4_ack_pulse", {15'd0, bus.ls_ack}, 16'h0000);
      stream(3);
      check("t4_mem20", {8'h00, mem[8'h20]}, 16'h005A);
      bus.ls_req = 1'b1;
      bus.ls_we  = 1'b0;
      #1;
      check("t4_ld_addr", {8'h00, bus.mem_address}, 16'h0020);
      accept();
      tick();
      check("t4_ld_ack", {15'd0, bus.ls_ack}, 16'h0001);
      check("t4_ld_rdata", {8'h00, bus.ls_rdata}, 16'h005A);
      check("t4_ack_state", {15'd0, bus.dbg_state}, 16'h0001);
      check("t4_ack_we", {15'd0, bus.mem_we}, 16'h0000);
      bus.ls_req = 1'b0;
      #1;
      stream(4);

      // jump to the top of memory and wrap
      exp_q.delete();
      bus.jump    = 1'b1;
      bus.jump_pc = 8'hFF;
      #1;
      tick();
      bus.jump = 1'b0;
      #1;
      check("t5_flushed", {15'd0, bus.ins_valid}, 16'h0000);
      tick(); check("t5_ff", {bus.ins_pc, bus.ins_data}, 16'hFFE7);
      tick(); check("t5_00", {bus.ins_pc, bus.ins_data}, 16'h0000);
      tick(); check("t5_01", {bus.ins_pc, bus.ins_data}, 16'h0100);

      // asynchronous reset mid-stream with a store request pending
      mem[8'h30]   = 8'h00;
      rst          = 1'b1;
      bus.ls_req   = 1'b1;
      bus.ls_we    = 1'b1;
      bus.ls_addr  = 8'h30;
      bus.ls_wdata = 8'h77;
      #1;
      check("t6_valid", {15'd0, bus.ins_valid}, 16'h0000);
      check("t6_ack", {15'd0, bus.ls_ack}, 16'h0000);
      check("t6_we", {15'd0, bus.mem_we}, 16'h0000);
      tick();
      check("t6_we_held", {15'd0, bus.mem_we}, 16'h0000);
      tick();
      rst        = 1'b0;
      bus.ls_req = 1'b0;
      #1;
      check("t6_restart_addr", {8'h00, bus.mem_address}, 16'h0000);
      check("t6_no_ack0", {15'd0, bus.ls_ack}, 16'h0000);
      tick();
      check("t6_head", {bus.ins_pc, 7'd0, bus.ins_valid}, 16'h0001);
      check("t6_no_ack1", {15'd0, bus.ls_ack}, 16'h0000);
      check("t6_mem30", {8'h00, mem[8'h30]}, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
